// File: rtl/count_n.sv
// rtl/count_n.sv - parametrised up/down counter with wrap, saturate and one-shot modes
// Chained instances cascade through tc feeding the next stage's en.
module count_n #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done,
  output logic             running
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             done_nxt;
  logic             term;
  logic             oneshot;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] linear_val;
  logic [WIDTH-1:0] wrap_val;

  assign oneshot    = (mode == MODE_ONE);
  assign term       = dir ? (out == limit) : (out == '0);
  assign inc_val    = out + 1'b1;
  assign dec_val    = out - 1'b1;
  assign linear_val = dir ? inc_val : dec_val;
  // Wrapping down reloads from limit rather than rolling to all-ones.
  assign wrap_val   = term ? (dir ? '0 : limit) : linear_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      out   <= RESET_VAL;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= out_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!oneshot) begin
      state_nxt = S_IDLE;
    end else if (clr) begin
      state_nxt = S_IDLE;
    end else if (load) begin
      state_nxt = S_RUN;
    end else if (state == S_RUN && en && term) begin
      state_nxt = S_HALT;
    end
  end

  always_comb begin
    out_nxt  = out;
    done_nxt = done;
    if (clr) begin
      out_nxt  = RESET_VAL;
      done_nxt = 1'b0;
    end else if (load) begin
      out_nxt  = load_val;
      done_nxt = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_SAT: begin
          if (term) begin
            done_nxt = 1'b1;
          end else begin
            out_nxt  = linear_val;
            done_nxt = 1'b0;
          end
        end
        MODE_ONE: begin
          // The terminal step is swallowed: out parks on the terminal value.
          if (state == S_RUN) begin
            if (term) begin
              done_nxt = 1'b1;
            end else begin
              out_nxt = wrap_val;
            end
          end
        end
        default: out_nxt = wrap_val;
      endcase
    end
  end

  assign tc      = reset & en & term & ~clr & ~load & (~oneshot | (state == S_RUN));
  assign running = (state == S_RUN);

endmodule
